// File: rtl/npc_pcreg_ras.sv
// npc_pcreg_ras: F-stage PC register, next-PC select, fetch-address check and return-address stack (optional, macro NPC_RAS_EN)
module npc_pcreg_ras #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE   = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             F_stall,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  input  logic             D_valid,
  input  logic             D_is_br,
  input  logic             D_br_taken,
  input  logic             D_is_j,
  input  logic             D_is_jal,
  input  logic             D_is_jr,
  input  logic             D_rs_is_ra,
  input  logic [25:0]      D_imm,
  input  logic [31:0]      D_rs_val,
  output logic [31:0]      F_PC,
  output logic [31:0]      D_PC8,
  output logic             F_adel,
  output logic [CNT_W-1:0] ras_hit_cnt,
  output logic [CNT_W-1:0] ras_miss_cnt
);
  logic [31:0] r_pc;
  logic [31:0] w_pc4, w_d_pc, w_br_tgt, w_j_tgt, w_npc;
  logic [32:0] w_lim;
  assign w_pc4    = r_pc + 32'd4;
  assign w_d_pc   = r_pc - 32'd4;
  assign w_br_tgt = r_pc + {{14{D_imm[15]}}, D_imm[15:0], 2'b00};
  assign w_j_tgt  = {w_d_pc[31:28], D_imm, 2'b00};
  assign w_lim    = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
  // Next-PC priority: exception, eret, stall, branch, jump, jr, sequential
  always_comb
    w_npc = exc_req                           ? EXC_VEC  :
            eret_req                          ? epc      :
            F_stall                           ? r_pc     :
            (D_valid & D_is_br & D_br_taken)  ? w_br_tgt :
            (D_valid & D_is_j)                ? w_j_tgt  :
            (D_valid & D_is_jr)               ? D_rs_val : w_pc4;
  // Fetch PC register
  always_ff @(posedge clk)
    if (!reset) r_pc <= RESET_PC;
    else        r_pc <= w_npc;
  assign F_PC   = r_pc;
  assign D_PC8  = w_pc4;
  assign F_adel = (r_pc[1:0] != 2'b00) | (r_pc < IM_BASE) | ({1'b0, r_pc} >= w_lim);
`ifdef NPC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  logic [31:0]      r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_ptr, w_top;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_hit, r_miss;
  logic             w_adv, w_push, w_pop, w_hit, w_miss;
  assign w_adv  = D_valid & ~F_stall & ~exc_req & ~eret_req;
  assign w_push = w_adv & D_is_jal;
  assign w_pop  = w_adv & D_is_jr & D_rs_is_ra;
  assign w_top  = r_ptr - PW'(1);
  assign w_hit  = w_pop & (r_cnt != '0) & (r_ras[w_top] == D_rs_val);
  assign w_miss = w_pop & ~w_hit;
  // Stack storage: jal writes its link address at the pointer, overwriting the oldest entry when full
  always_ff @(posedge clk)
    if (reset && w_push) r_ras[r_ptr] <= w_pc4;
  // Pointer and occupancy; a pop on an empty stack leaves both unchanged
  always_ff @(posedge clk)
    if (!reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + PW'(1);
      r_cnt <= (r_cnt == CW'(RAS_DEPTH)) ? r_cnt : r_cnt + CW'(1);
    end else if (w_pop && r_cnt != '0) begin
      r_ptr <= w_top;
      r_cnt <= r_cnt - CW'(1);
    end
  // Saturating prediction hit/miss counters
  always_ff @(posedge clk)
    if (!reset) begin
      r_hit  <= '0;
      r_miss <= '0;
    end else begin
      if (w_hit && !(&r_hit))   r_hit  <= r_hit + CNT_W'(1);
      if (w_miss && !(&r_miss)) r_miss <= r_miss + CNT_W'(1);
    end
  assign ras_hit_cnt  = r_hit;
  assign ras_miss_cnt = r_miss;
`else
  logic w_unused;
  assign w_unused     = ^{D_is_jal, D_rs_is_ra};
  assign ras_hit_cnt  = '0;
  assign ras_miss_cnt = '0;
`endif
endmodule

// File: doc/npc_pcreg_ras.md
Name: npc_pcreg_ras

Overview:
- Next-generation fetch-address unit for the 5-stage MIPS pipeline.
- Owns the F-stage PC register and selects the next PC from sequential, branch, jump, jr, exception-entry and eret sources.
- Adds a parametrised return-address stack (RAS) that checks jr $ra targets, plus instruction-address-error detection.
- Sits between the D-stage decoder/comparator and the instruction memory; the CP0/M stage supplies the exception/eret controls.

Parameters:
- RESET_PC, 32'h0000_3000, F_PC value after reset.
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_SIZE, 32'h0000_3000, legal fetch window size in bytes.
- RAS_DEPTH, 4, RAS entries; power of two, >=2.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- F_stall  in  1  hold F_PC (hazard stall).
- exc_req  in  1  exception/interrupt taken this cycle.
- eret_req  in  1  eret committing; redirect to epc.
- epc  in  32  CP0 EPC.
- D_valid  in  1  D-stage instruction is real (not a bubble).
- D_is_br  in  1  D instruction is beq/bne.
- D_br_taken  in  1  branch condition true.
- D_is_j  in  1  j or jal.
- D_is_jal  in  1  jal (D_is_j also 1).
- D_is_jr  in  1  jr.
- D_rs_is_ra  in  1  jr source register is $31.
- D_imm  in  26  instr[25:0].
- D_rs_val  in  32  forwarded rs value.
- F_PC  out  32  registered fetch address.
- D_PC8  out  32  link value = F_PC + 4.
- F_adel  out  1  fetch address error.
- ras_hit_cnt  out  CNT_W  jr $ra predictions correct.
- ras_miss_cnt  out  CNT_W  jr $ra predictions wrong or empty.

Behaviour:
- Reset (reset==0 at posedge): F_PC=RESET_PC; RAS empty (count=0, ptr=0); both counters 0. Reset wins over every other input, including mid-operation.
- D_PC = F_PC-4. Branch target = F_PC + {sext(D_imm[15:0]),2'b00}. Jump target = {D_PC[31:28],D_imm,2'b00}.
- F_PC update priority per posedge: exc_req -> EXC_VEC; else eret_req -> epc; else F_stall -> hold; else D_valid&D_is_br&D_br_taken -> branch target; else D_valid&D_is_j -> jump target; else D_valid&D_is_jr -> D_rs_val; else F_PC+4.
- exc_req and eret_req override F_stall. If both are asserted, exc_req wins.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0, which raises F_adel.
- F_adel is combinational: F_PC[1:0]!=0 or F_PC<IM_BASE or F_PC>=IM_BASE+IM_SIZE.
- RAS updates only when an instruction advances: D_valid & ~F_stall & ~exc_req & ~eret_req.
- Push on jal: write D_PC+8 at ptr; ptr=ptr+1 mod RAS_DEPTH; count=min(count+1,RAS_DEPTH). On overflow the oldest entry is overwritten.
- Pop on jr with D_rs_is_ra:
  - count>0: compare entry at ptr-1 with D_rs_val; equal -> ras_hit_cnt+1, else ras_miss_cnt+1; then ptr-1 and count-1.
  - count==0: ras_miss_cnt+1; pointer and count unchanged.
- jr with a source other than $ra leaves the RAS untouched.
- Counters saturate at all-ones.
- RAS never affects F_PC; the resolved D_rs_val is always used, so the RAS cannot cause wrong-path fetch.
- Exception, eret and stall do not modify RAS contents.

Optional Feature:
- NPC_RAS_EN.
- Defined: RAS storage and counters exist as described.
- Undefined: no RAS storage, ras_hit_cnt and ras_miss_cnt are tied to 0, and F_PC/F_adel behaviour is identical.

Test Plan:
- Reset low for 2 cycles, then high, no D activity -> F_PC 3000, 3004, 3008; F_adel=0; counters 0.
- F_PC=3010, D_is_br=1, D_br_taken=1, D_imm=16'hFFFC -> next F_PC=3000. Repeat with F_stall=1 -> F_PC holds 3010.
- F_PC=3008, jal with D_imm=26'h0000C10 -> F_PC=3040, D_PC8 was 300C. Later jr $ra with D_rs_val=300C -> F_PC=300C, ras_hit_cnt=1.
- Five jal pushes, RAS_DEPTH=4, then five jr $ra pops with matching values -> 4 hits, then 1 miss (empty); count never exceeds 4.
- exc_req=1 and eret_req=1 with F_stall=1 -> F_PC=4180; next cycle eret_req=1, epc=3020 -> F_PC=3020.
- jr with D_rs_val=3002 -> F_PC=3002, F_adel=1. jr to 6000 -> F_adel=1. jr to 2FFC -> F_adel=1.
